normalize_round: RTL and testbench

Iterative post-normalization and round-to-nearest-even stage. It sits directly downstream of the shift-and-extend stage in the low-cost FPU datapath. It takes a 32-bit extended mantissa, the associated sticky bit and a provisional biased exponent, and shifts one bit per cycle until the hidden 1 sits at bit 23. It then rounds the result and returns an IEEE-754 single-precision exponent/fraction pair with status flags, using a start/done handshake.

---
 rtl/normalize_round.sv | 163 ++++++++++++++++
 tb/tb_normalize_round.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/normalize_round.sv
// Iterative post-normalization and round-to-nearest-even stage for single precision.
// Shifts one bit per cycle until the hidden 1 sits at bit 23, rounds, and reports status flags.
module normalize_round (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        start_in,
  input  logic [31:0] operand_in,
  input  logic        stickyBit_in,
  input  logic [9:0]  exponent_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [22:0] fraction_out,
  output logic [7:0]  exponent_out,
  output logic        overflow_out,
  output logic        underflow_out,
  output logic        inexact_out
);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ROUND, S_POST, S_FINISH} state_t;

  state_t             r_state, w_state_nxt;
  logic [33:0]        r_w, w_w_nxt;
  logic               r_s, w_s_nxt;
  logic signed [9:0]  r_e, w_e_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_inex, w_inex_nxt;
  logic               r_done;
  logic [22:0]        r_frac;
  logic [7:0]         r_exp;
  logic               r_ovf, r_unf, r_inex_out;

  logic               w_rbit;
  logic               w_inc;
  logic [31:0]        w_sum;

  // Round-to-nearest-even increment decision from guard, round|sticky and fraction LSB.
  function automatic logic rne_inc(input logic guard, input logic rs, input logic lsb);
    return guard & (rs | lsb);
  endfunction

  assign w_rbit = r_w[0] | r_s;
  assign w_inc  = rne_inc(r_w[1], w_rbit, r_w[2]);
  assign w_sum  = r_w[33:2] + {31'd0, w_inc};

  assign busy_out      = (r_state != S_IDLE);
  assign done_out      = r_done;
  assign fraction_out  = r_frac;
  assign exponent_out  = r_exp;
  assign overflow_out  = r_ovf;
  assign underflow_out = r_unf;
  assign inexact_out   = r_inex_out;

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_s_nxt     = r_s;
    w_e_nxt     = r_e;
    w_zero_nxt  = r_zero;
    w_inex_nxt  = r_inex;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_w_nxt     = {operand_in, 2'b00};
          w_s_nxt     = stickyBit_in;
          w_e_nxt     = $signed(exponent_in);
          w_zero_nxt  = 1'b0;
          w_inex_nxt  = 1'b0;
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (r_w == 34'd0) begin
          w_zero_nxt  = 1'b1;
          w_inex_nxt  = r_s;
          w_state_nxt = S_FINISH;
        end else if (|r_w[33:26]) begin
          w_s_nxt = r_s | r_w[0];
          w_w_nxt = r_w >> 1;
          w_e_nxt = r_e + 10'sd1;
        end else if (!r_w[25]) begin
          w_w_nxt = r_w << 1;
          w_e_nxt = r_e - 10'sd1;
        end else begin
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        w_w_nxt     = {w_sum, 2'b00};
        w_s_nxt     = 1'b0;
        w_inex_nxt  = r_w[1] | w_rbit;
        // A carry out of the fraction lands in bit 26 and needs one renormalizing shift.
        w_state_nxt = w_sum[24] ? S_POST : S_FINISH;
      end
      S_POST: begin
        w_w_nxt     = r_w >> 1;
        w_e_nxt     = r_e + 10'sd1;
        w_state_nxt = S_FINISH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_s     <= 1'b0;
      r_e     <= '0;
      r_zero  <= 1'b0;
      r_inex  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_s     <= w_s_nxt;
      r_e     <= w_e_nxt;
      r_zero  <= w_zero_nxt;
      r_inex  <= w_inex_nxt;
    end
  end

  // Result registers update only on the FINISH edge and hold otherwise.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_done     <= 1'b0;
      r_frac     <= '0;
      r_exp      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_inex_out <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      if (r_state == S_FINISH) begin
        if (r_zero) begin
          r_frac     <= '0;
          r_exp      <= '0;
          r_ovf      <= 1'b0;
          r_unf      <= 1'b0;
          r_inex_out <= r_inex;
        end else if (r_e >= 10'sd255) begin
          r_frac     <= '0;
          r_exp      <= 8'hFF;
          r_ovf      <= 1'b1;
          r_unf      <= 1'b0;
          r_inex_out <= 1'b1;
        end else if (r_e <= 10'sd0) begin
          r_frac     <= '0;
          r_exp      <= '0;
          r_ovf      <= 1'b0;
          r_unf      <= 1'b1;
          r_inex_out <= 1'b1;
        end else begin
          r_frac     <= r_w[24:2];
          r_exp      <= r_e[7:0];
          r_ovf      <= 1'b0;
          r_unf      <= 1'b0;
          r_inex_out <= r_inex;
        end
      end
    end
  end

endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round: hand-computed vectors for rounding, shifting,
// overflow/underflow, zero and mid-operation reset.
module tb_normalize_round;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] operand;
  logic        sticky;
  logic [9:0]  expo;
  logic        busy, done;
  logic [22:0] frac;
  logic [7:0]  exp_out;
  logic        ovf, unf, inex;

  int n_checks = 0;
  int n_errors = 0;

  normalize_round dut (
    .clk_in        (clk),
    .reset_n_in    (rst_n),
    .start_in      (start),
    .operand_in    (operand),
    .stickyBit_in  (sticky),
    .exponent_in   (expo),
    .busy_out      (busy),
    .done_out      (done),
    .fraction_out  (frac),
    .exponent_out  (exp_out),
    .overflow_out  (ovf),
    .underflow_out (unf),
    .inexact_out   (inex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Issues one request and returns the edge index after which done was seen (-1 on timeout).
  task automatic run(input logic [31:0] op, input logic st, input logic [9:0] ex, output int lat);
    operand = op;
    sticky  = st;
    expo    = ex;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int lat_want,
                               input logic [7:0] e, input logic [22:0] f,
                               input logic o, input logic u, input logic x);
    check({tag, "_lat"},  lat, lat_want);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_exp"},  {24'd0, exp_out}, {24'd0, e});
    check({tag, "_frac"}, {9'd0, frac}, {9'd0, f});
    check({tag, "_flags"}, {29'd0, ovf, unf, inex}, {29'd0, o, u, x});
  endtask

  initial begin
    int lat;
    int done_seen;
    rst_n   = 1'b0;
    start   = 1'b0;
    operand = '0;
    sticky  = 1'b0;
    expo    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_outs", {ovf, unf, inex, exp_out, frac}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(32'h0080_0000, 1'b0, 10'd127, lat);
    expect_result("normalized", lat, 3, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0);

    // Start asserted in the done cycle is accepted on the next edge.
    run(32'h0180_0003, 1'b0, 10'd127, lat);
    expect_result("rne_up", lat, 4, 8'd128, 23'h400002, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("hold_frac", {9'd0, frac}, 32'h0040_0002);
    check("hold_done", {31'd0, done}, 32'd0);

    run(32'h0180_0001, 1'b0, 10'd127, lat);
    expect_result("tie_even", lat, 4, 8'd128, 23'h400000, 1'b0, 1'b0, 1'b1);

    run(32'h01FF_FFFF, 1'b0, 10'd127, lat);
    expect_result("rnd_carry", lat, 5, 8'd129, 23'h000000, 1'b0, 1'b0, 1'b1);

    run(32'h0000_0001, 1'b0, 10'd150, lat);
    expect_result("long_left", lat, 26, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0);

    run(32'h0000_0001, 1'b0, 10'd10, lat);
    expect_result("flush", lat, 26, 8'd0, 23'h000000, 1'b0, 1'b1, 1'b1);

    run(32'h0000_0000, 1'b1, 10'd127, lat);
    expect_result("zero", lat, 2, 8'd0, 23'h000000, 1'b0, 1'b0, 1'b1);

    run(32'h0080_0000, 1'b0, 10'd255, lat);
    expect_result("overflow", lat, 3, 8'd255, 23'h000000, 1'b1, 1'b0, 1'b1);

    // Abort a long left-shift sequence with an asynchronous reset.
    operand = 32'h0000_0001;
    sticky  = 1'b0;
    expo    = 10'd150;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_outs", {ovf, unf, inex, exp_out, frac}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run(32'h0180_0003, 1'b0, 10'd127, lat);
    expect_result("after_abort", lat, 4, 8'd128, 23'h400002, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
